player_motion_ctrl: RTL and testbench

PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

---
 rtl/player_motion_ctrl_pkg.sv | 73 +++++++
 rtl/player_motion_ctrl_frame_tick_gen.sv | 33 +++
 rtl/player_motion_ctrl.sv | 153 +++++++++++++++
 tb/tb_player_motion_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/player_motion_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl_pkg
// Shared definitions for the player/missile motion controller:
//   - coordinate and arithmetic widths
//   - default screen constants (player row, horizontal limits, start column)
//   - missile FSM state encoding
//   - next_player_x(): one frame of horizontal player movement
// Configuration macro: PLAYER_WRAP_EN
//   undefined -> player_x clamps at X_MIN / X_MAX
//   defined   -> leaving the left edge lands on X_MAX, leaving the right edge
//                lands on X_MIN
// -----------------------------------------------------------------------------
package player_motion_ctrl_pkg;

  localparam int COORD_W = 9;   // screen coordinate width
  localparam int CALC_W  = 10;  // movement arithmetic width (one guard bit)
  localparam int CD_W    = 8;   // cooldown frame counter width

  localparam int DEF_PLAYER_X_INIT = 128;
  localparam int DEF_PLAYER_Y      = 200;
  localparam int DEF_X_MIN         = 8;
  localparam int DEF_X_MAX         = 240;

  typedef enum logic [1:0] {
    MS_IDLE     = 2'd0,
    MS_FLY      = 2'd1,
    MS_COOLDOWN = 2'd2
  } missile_state_t;

  // One frame of player movement. Both buttons (or neither) hold position.
  function automatic logic [COORD_W-1:0] next_player_x(
    input logic [COORD_W-1:0] x,
    input logic               left,
    input logic               right,
    input logic [COORD_W-1:0] step,
    input logic [COORD_W-1:0] x_min,
    input logic [COORD_W-1:0] x_max
  );
    logic [CALC_W-1:0] x_ext;
    logic [CALC_W-1:0] sum;
    logic [CALC_W-1:0] step_ext;
    logic              under;
    logic              over;
    logic [COORD_W-1:0] result;
    x_ext    = {1'b0, x};
    step_ext = {1'b0, step};
    sum      = x_ext;
    under    = 1'b0;
    over     = 1'b0;
    if (left && !right) begin
      // Compare before subtracting so a small x cannot wrap through zero.
      under = (x_ext < ({1'b0, x_min} + step_ext));
      sum   = x_ext - step_ext;
    end else if (right && !left) begin
      sum  = x_ext + step_ext;
      over = (sum > {1'b0, x_max});
    end
    result = sum[COORD_W-1:0];
`ifdef PLAYER_WRAP_EN
    if (under)
      result = x_max;
    else if (over)
      result = x_min;
`else
    if (under)
      result = x_min;
    else if (over)
      result = x_max;
`endif
    return result;
  endfunction

endpackage

// File: rtl/player_motion_ctrl_frame_tick_gen.sv
// -----------------------------------------------------------------------------
// frame_tick_gen
// Registers vsync and emits a single-cycle frame_tick one cycle after the
// sampled vsync rises.
// Ports:
//   clk        in  system clock
//   reset      in  synchronous active-low reset
//   vsync      in  vertical sync from the video timing generator
//   frame_tick out one-cycle pulse per frame (registered)
// -----------------------------------------------------------------------------
module frame_tick_gen (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic frame_tick
);

  logic vsync_reg;
  logic vsync_prev_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vsync_reg      <= 1'b0;
      vsync_prev_reg <= 1'b0;
      frame_tick     <= 1'b0;
    end else begin
      vsync_reg      <= vsync;
      vsync_prev_reg <= vsync_reg;
      frame_tick     <= vsync_reg & ~vsync_prev_reg;
    end
  end

endmodule

// File: rtl/player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// player_motion_ctrl
// Moves the player horizontally from button input once per frame and runs a
// single missile (IDLE -> FLY -> COOLDOWN -> IDLE).
// Ports:
//   clk            in  system clock
//   reset          in  synchronous active-low reset
//   vsync          in  vertical sync (frame timing)
//   btn_left       in  raw button, asynchronous
//   btn_right      in  raw button, asynchronous
//   btn_fire       in  raw button, asynchronous
//   missile_hit    in  collision pulse, acted on in any cycle while flying
//   player_x/_y    out player sprite position (9 bit)
//   missile_x/_y   out missile position (9 bit), held while inactive
//   missile_active out missile in flight
//   frame_tick     out one-cycle pulse per frame
// Configuration macro: PLAYER_WRAP_EN (horizontal wrap instead of clamp)
// -----------------------------------------------------------------------------
module player_motion_ctrl
  import player_motion_ctrl_pkg::*;
#(
  parameter int PLAYER_X_INIT   = DEF_PLAYER_X_INIT,
  parameter int PLAYER_Y        = DEF_PLAYER_Y,
  parameter int X_MIN           = DEF_X_MIN,
  parameter int X_MAX           = DEF_X_MAX,
  parameter int STEP            = 2,
  parameter int MISSILE_STEP    = 4,
  parameter int MISSILE_Y_TOP   = 8,
  parameter int COOLDOWN_FRAMES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_fire,
  input  logic               missile_hit,
  output logic [COORD_W-1:0] player_x,
  output logic [COORD_W-1:0] player_y,
  output logic [COORD_W-1:0] missile_x,
  output logic [COORD_W-1:0] missile_y,
  output logic               missile_active,
  output logic               frame_tick
);

  localparam logic [COORD_W-1:0] X_INIT_C   = COORD_W'(PLAYER_X_INIT);
  localparam logic [COORD_W-1:0] PLAYER_Y_C = COORD_W'(PLAYER_Y);
  localparam logic [COORD_W-1:0] X_MIN_C    = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C    = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] STEP_C     = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] M_STEP_C   = COORD_W'(MISSILE_STEP);
  localparam logic [CALC_W-1:0]  RETIRE_C   = CALC_W'(MISSILE_Y_TOP + MISSILE_STEP);
  localparam logic [CD_W-1:0]    CD_LOAD_C  = CD_W'(COOLDOWN_FRAMES);

  // Button synchronizers, bit order {fire, right, left}.
  logic [2:0] btn_raw;
  logic [2:0] sync1_reg;
  logic [2:0] sync2_reg;
  logic       left_s, right_s, fire_s;

  assign btn_raw = {btn_fire, btn_right, btn_left};

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg <= 3'b000;
      sync2_reg <= 3'b000;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
    end
  end

  assign left_s  = sync2_reg[0];
  assign right_s = sync2_reg[1];
  assign fire_s  = sync2_reg[2];

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .frame_tick (frame_tick)
  );

  logic [COORD_W-1:0] player_x_reg;
  logic [COORD_W-1:0] missile_x_reg;
  logic [COORD_W-1:0] missile_y_reg;
  logic               missile_active_reg;
  logic [CD_W-1:0]    cooldown_reg;
  logic               fire_prev_reg;   // fire as seen at the previous tick
  missile_state_t     state_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      player_x_reg       <= X_INIT_C;
      missile_x_reg      <= '0;
      missile_y_reg      <= '0;
      missile_active_reg <= 1'b0;
      cooldown_reg       <= '0;
      fire_prev_reg      <= 1'b0;
      state_reg          <= MS_IDLE;
    end else begin
      if (frame_tick) begin
        player_x_reg  <= next_player_x(player_x_reg, left_s, right_s,
                                       STEP_C, X_MIN_C, X_MAX_C);
        fire_prev_reg <= fire_s;
      end

      // A hit overrides whatever the missile would have done on this tick.
      if (missile_hit && (state_reg == MS_FLY)) begin
        state_reg          <= MS_COOLDOWN;
        missile_active_reg <= 1'b0;
        cooldown_reg       <= CD_LOAD_C;
      end else if (frame_tick) begin
        case (state_reg)
          MS_IDLE: begin
            if (fire_s && !fire_prev_reg) begin
              state_reg          <= MS_FLY;
              missile_x_reg      <= player_x_reg + COORD_W'(3);
              missile_y_reg      <= PLAYER_Y_C - COORD_W'(1);
              missile_active_reg <= 1'b1;
            end
          end
          MS_FLY: begin
            if ({1'b0, missile_y_reg} < RETIRE_C) begin
              state_reg          <= MS_COOLDOWN;
              missile_active_reg <= 1'b0;
              cooldown_reg       <= CD_LOAD_C;
            end else begin
              missile_y_reg <= missile_y_reg - M_STEP_C;
            end
          end
          MS_COOLDOWN: begin
            // A load of 0 or 1 both release on this tick.
            if (cooldown_reg <= CD_W'(1)) begin
              state_reg    <= MS_IDLE;
              cooldown_reg <= '0;
            end else begin
              cooldown_reg <= cooldown_reg - CD_W'(1);
            end
          end
          default: state_reg <= MS_IDLE;
        endcase
      end
    end
  end

  assign player_x       = player_x_reg;
  assign player_y       = PLAYER_Y_C;
  assign missile_x      = missile_x_reg;
  assign missile_y      = missile_y_reg;
  assign missile_active = missile_active_reg;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_motion_ctrl
// Directed and randomized frames against a behavioural model of the player /
// missile rules. Honours PLAYER_WRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_player_motion_ctrl;

  localparam int X_INIT = 128;
  localparam int P_Y    = 200;
  localparam int XMIN   = 8;
  localparam int XMAX   = 240;
  localparam int STP    = 2;
  localparam int MSTP   = 4;
  localparam int MTOP   = 8;
  localparam int CDF    = 3;
  localparam int BLOCK_TICKS = (CDF > 0) ? CDF : 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic vsync = 1'b0;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic btn_fire = 1'b0;
  logic missile_hit = 1'b0;
  logic [8:0] player_x, player_y, missile_x, missile_y;
  logic missile_active, frame_tick;

  int compared = 0;
  int mismatched = 0;
  int tick_cnt = 0;

  // Reference model state
  int m_px, m_mx, m_my, m_blocked;
  bit m_act, m_prev_fire;

  player_motion_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .vsync          (vsync),
    .btn_left       (btn_left),
    .btn_right      (btn_right),
    .btn_fire       (btn_fire),
    .missile_hit    (missile_hit),
    .player_x       (player_x),
    .player_y       (player_y),
    .missile_x      (missile_x),
    .missile_y      (missile_y),
    .missile_active (missile_active),
    .frame_tick     (frame_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_tick === 1'b1) tick_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_px = X_INIT; m_mx = 0; m_my = 0; m_act = 0; m_blocked = 0; m_prev_fire = 0;
  endtask

  // One frame of the game rules: player moves, then the missile acts with the
  // pre-move player column; a hit on this frame beats the frame's missile step.
  task automatic model_frame(input bit l, input bit r, input bit f, input bit hit);
    int old_px;
    old_px = m_px;
    if (l && !r) m_px = m_px - STP;
    else if (r && !l) m_px = m_px + STP;
`ifdef PLAYER_WRAP_EN
    if (m_px < XMIN) m_px = XMAX; else if (m_px > XMAX) m_px = XMIN;
`else
    if (m_px < XMIN) m_px = XMIN; else if (m_px > XMAX) m_px = XMAX;
`endif
    if (m_act && hit) begin
      m_act = 0; m_blocked = BLOCK_TICKS;
    end else if (m_act) begin
      if (m_my < MTOP + MSTP) begin m_act = 0; m_blocked = BLOCK_TICKS; end
      else m_my = m_my - MSTP;
    end else if (m_blocked > 0) begin
      m_blocked--;
    end else if (f && !m_prev_fire) begin
      m_act = 1; m_mx = (old_px + 3) % 512; m_my = P_Y - 1;
    end
    m_prev_fire = f;
  endtask

  task automatic check_state();
    check("player_x", 32'(player_x), m_px);
    check("player_y", 32'(player_y), P_Y);
    check("missile_active", 32'(missile_active), 32'(m_act));
    check("missile_x", 32'(missile_x), m_mx);
    check("missile_y", 32'(missile_y), m_my);
  endtask

  // Hold buttons, raise vsync, verify tick timing/width, then the frame result.
  task automatic do_frame(input bit l, input bit r, input bit f, input bit hit);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_fire = f;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    @(negedge clk);
    check("tick_lead", 32'(frame_tick), 0);
    @(negedge clk);
    check("tick_pulse", 32'(frame_tick), 1);
    missile_hit = hit;
    @(negedge clk);
    missile_hit = 1'b0;
    check("tick_width", 32'(frame_tick), 0);
    model_frame(l, r, f, hit);
    check_state();
    $display("frame L=%0d R=%0d F=%0d H=%0d -> px=%0d act=%0d mx=%0d my=%0d",
             l, r, f, hit, player_x, missile_active, missile_x, missile_y);
    vsync = 1'b0;
  endtask

  // Collision pulse away from any tick.
  task automatic pulse_hit();
    @(negedge clk);
    missile_hit = 1'b1;
    @(negedge clk);
    missile_hit = 1'b0;
    if (m_act) begin m_act = 0; m_blocked = BLOCK_TICKS; end
    check("hit_active", 32'(missile_active), 32'(m_act));
    check("hit_my", 32'(missile_y), m_my);
    $display("hit pulse -> act=%0d", missile_active);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_reset();
    check_state();
    check("rst_tick", 32'(frame_tick), 0);
    $display("reset -> px=%0d act=%0d mx=%0d my=%0d", player_x, missile_active, missile_x, missile_y);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int t0;
    bit rl, rr, rf, rh;
    model_reset();

    // Power-on reset
    do_reset();

    // Idle frames: position holds, exactly one tick per frame
    t0 = tick_cnt;
    repeat (5) do_frame(0, 0, 0, 0);
    check("idle_px", 32'(player_x), 128);
    check("idle_active", 32'(missile_active), 0);
    check("tick_count", tick_cnt - t0, 5);

    // Move right to the limit
    repeat (10) do_frame(0, 1, 0, 0);
    check("right10_px", 32'(player_x), 148);
    repeat (46) do_frame(0, 1, 0, 0);
    check("right_at_max", 32'(player_x), 240);
    do_frame(0, 1, 0, 0);
`ifdef PLAYER_WRAP_EN
    check("right_past_max", 32'(player_x), 8);
`else
    check("right_past_max", 32'(player_x), 240);
`endif
    repeat (3) do_frame(0, 1, 0, 0);

    // Back to 128 then left to 100; both buttons hold
    do_reset();
    repeat (14) do_frame(1, 0, 0, 0);
    check("left14_px", 32'(player_x), 100);
    repeat (4) do_frame(1, 1, 0, 0);
    check("both_px", 32'(player_x), 100);

    // Launch, climb, retire with fire still held: no relaunch
    do_frame(0, 0, 1, 0);
    check("launch_mx", 32'(missile_x), 103);
    check("launch_my", 32'(missile_y), 199);
    check("launch_act", 32'(missile_active), 1);
    do_frame(0, 0, 1, 0);
    check("climb_my", 32'(missile_y), 195);
    repeat (60) do_frame(0, 0, 1, 0);
    check("held_no_relaunch", 32'(missile_active), 0);
    do_frame(0, 0, 0, 0);
    do_frame(0, 0, 1, 0);
    check("relaunch_act", 32'(missile_active), 1);

    // Hit on a tick, then cooldown gating of fire
    do_frame(0, 0, 0, 1);
    check("hit_tick_act", 32'(missile_active), 0);
    do_frame(0, 0, 1, 0);
    do_frame(0, 0, 0, 0);
    do_frame(0, 0, 0, 0);
    check("cooldown_act", 32'(missile_active), 0);
    do_frame(0, 0, 1, 0);
    check("after_cd_act", 32'(missile_active), 1);

    // Hit outside a tick while flying, then while idle (ignored)
    pulse_hit();
    repeat (4) do_frame(0, 0, 0, 0);
    pulse_hit();

    // Reset in flight
    do_frame(0, 0, 1, 0);
    check("pre_rst_act", 32'(missile_active), 1);
    do_reset();

    // Randomized play
    for (int i = 0; i < 150; i++) begin
      rl = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rf = 1'($urandom_range(0, 1));
      rh = ($urandom_range(0, 5) == 0);
      do_frame(rl, rr, rf, rh);
      if ($urandom_range(0, 3) == 0) pulse_hit();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
